fixed_linear_input_scheduler: RTL and testbench

- Sequences input activations into `fixed_linear` when a layer's output features exceed one `PARALLELISM` tile.
- Captures one input vector as `IN_DEPTH` beats of `IN_SIZE` elements into an internal register buffer.
- Replays the buffered vector `OUT_DEPTH` times, once per output tile, with matching weight-tile and bias-tile addresses for the weight/bias fetch logic.
- Sits between the upstream activation stream and the `fixed_linear` `data_in` port.

---
 rtl/fixed_linear_input_scheduler.sv | 108 ++++++++++
 tb/tb_fixed_linear_input_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_linear_input_scheduler.sv
// Buffers one IN_DEPTH-beat input vector, then replays it OUT_DEPTH times with
// matching weight/bias tile addresses for the downstream fixed_linear block.
module fixed_linear_input_scheduler #(
   parameter int IN_WIDTH    = 32,
   parameter int IN_SIZE     = 4,
   parameter int IN_DEPTH    = 3,
   parameter int OUT_DEPTH   = 2,
   parameter int WADDR_WIDTH = (IN_DEPTH * OUT_DEPTH > 1) ? $clog2(IN_DEPTH * OUT_DEPTH) : 1,
   parameter int BADDR_WIDTH = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [IN_SIZE-1:0][IN_WIDTH-1:0]  data_in,
   input  logic                              data_in_valid,
   output logic                              data_in_ready,
   output logic [IN_SIZE-1:0][IN_WIDTH-1:0]  data_out,
   output logic                              data_out_valid,
   input  logic                              data_out_ready,
   output logic [WADDR_WIDTH-1:0]            weight_addr,
   output logic [BADDR_WIDTH-1:0]            bias_addr,
   output logic                              tile_last,
   output logic                              vector_last,
   output logic                              busy
);

   localparam int DW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
   localparam int OW = BADDR_WIDTH;
   localparam logic [DW-1:0] D_LAST = DW'(IN_DEPTH - 1);
   localparam logic [OW-1:0] O_LAST = OW'(OUT_DEPTH - 1);

   typedef enum logic {
      FILL   = 1'b0,
      REPLAY = 1'b1
   } state_t;

   state_t                            state_q, state_d;
   logic [DW-1:0]                     d_cnt_q, d_cnt_d;
   logic [OW-1:0]                     o_cnt_q, o_cnt_d;
   logic [IN_SIZE-1:0][IN_WIDTH-1:0]  vec_q [IN_DEPTH];

   logic replay;
   logic in_hs;
   logic out_hs;
   logic tile_last_w;
   logic vector_last_w;

   assign replay        = (state_q == REPLAY);
   assign in_hs         = !replay && data_in_valid;
   assign out_hs        = replay && data_out_ready;
   assign tile_last_w   = replay && (d_cnt_q == D_LAST);
   assign vector_last_w = tile_last_w && (o_cnt_q == O_LAST);

   // d_cnt indexes the beat in both states; o_cnt only moves during replay.
   always_comb begin
      state_d = state_q;
      d_cnt_d = d_cnt_q;
      o_cnt_d = o_cnt_q;
      if (in_hs) begin
         if (d_cnt_q == D_LAST) begin
            d_cnt_d = '0;
            o_cnt_d = '0;
            state_d = REPLAY;
         end else begin
            d_cnt_d = d_cnt_q + 1'b1;
         end
      end else if (out_hs) begin
         if (vector_last_w) begin
            d_cnt_d = '0;
            o_cnt_d = '0;
            state_d = FILL;
         end else if (tile_last_w) begin
            d_cnt_d = '0;
            o_cnt_d = o_cnt_q + 1'b1;
         end else begin
            d_cnt_d = d_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FILL;
         d_cnt_q <= '0;
         o_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         d_cnt_q <= d_cnt_d;
         o_cnt_q <= o_cnt_d;
      end
   end

   // Buffer contents need no reset: they are only read after a full fill.
   always_ff @(posedge clk) begin
      if (in_hs) begin
         vec_q[d_cnt_q] <= data_in;
      end
   end

   assign data_in_ready  = !replay;
   assign data_out_valid = replay;
   assign data_out       = vec_q[d_cnt_q];
   assign weight_addr    = replay ? WADDR_WIDTH'(int'(o_cnt_q) * IN_DEPTH + int'(d_cnt_q)) : '0;
   assign bias_addr      = replay ? o_cnt_q : '0;
   assign tile_last      = tile_last_w;
   assign vector_last    = vector_last_w;
   assign busy           = replay || (d_cnt_q != '0);

endmodule

// File: tb/tb_fixed_linear_input_scheduler.sv
// Randomized bench for fixed_linear_input_scheduler: a beat-list reference model
// checks every cycle; a second 1x1 instance covers the degenerate build.
module tb_fixed_linear_input_scheduler;

   localparam int W  = 32;
   localparam int S  = 4;
   localparam int ID = 3;
   localparam int OD = 2;
   localparam int WA = 3;
   localparam int BA = 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [S-1:0][W-1:0] data_in, data_out;
   logic                data_in_valid, data_in_ready, data_out_valid, data_out_ready;
   logic                tile_last, vector_last, busy;
   logic [WA-1:0]       weight_addr;
   logic [BA-1:0]       bias_addr;

   logic [S-1:0][W-1:0] d1_in, d1_out;
   logic                d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready;
   logic                d1_tl, d1_vl, d1_busy;
   logic [0:0]          d1_wa, d1_ba;

   fixed_linear_input_scheduler #(
      .IN_WIDTH(W), .IN_SIZE(S), .IN_DEPTH(ID), .OUT_DEPTH(OD),
      .WADDR_WIDTH(WA), .BADDR_WIDTH(BA)
   ) dut (
      .clk(clk), .rst(rst),
      .data_in(data_in), .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
      .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
      .weight_addr(weight_addr), .bias_addr(bias_addr),
      .tile_last(tile_last), .vector_last(vector_last), .busy(busy)
   );

   fixed_linear_input_scheduler #(
      .IN_WIDTH(W), .IN_SIZE(S), .IN_DEPTH(1), .OUT_DEPTH(1),
      .WADDR_WIDTH(1), .BADDR_WIDTH(1)
   ) dut1 (
      .clk(clk), .rst(rst),
      .data_in(d1_in), .data_in_valid(d1_in_valid), .data_in_ready(d1_in_ready),
      .data_out(d1_out), .data_out_valid(d1_out_valid), .data_out_ready(d1_out_ready),
      .weight_addr(d1_wa), .bias_addr(d1_ba),
      .tile_last(d1_tl), .vector_last(d1_vl), .busy(d1_busy)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: a vector is a list of beats; replay is that list walked
   // OUT_DEPTH times, flattened into a queue of expected output beats.
   typedef struct {
      logic [127:0] data;
      int           wa;
      int           ba;
      bit           tl;
      bit           vl;
   } beat_t;

   beat_t        exp_q[$];
   logic [127:0] vec [ID];
   bit           m_fill     = 1'b1;
   int           m_cnt      = 0;
   int           out_hs_cnt = 0;
   int           vec_done   = 0;
   bit           mon_en     = 1'b0;

   always @(negedge clk) begin
      beat_t e;
      beat_t b;
      if (rst) begin
         exp_q.delete();
         m_fill = 1'b1;
         m_cnt  = 0;
      end else if (mon_en) begin
         check("in_ready", 128'(data_in_ready), 128'(m_fill));
         check("out_valid", 128'(data_out_valid), 128'(!m_fill));
         check("busy", 128'(busy), 128'(!m_fill || m_cnt != 0));
         if (m_fill) begin
            if (data_in_valid) begin
               vec[m_cnt] = data_in;
               m_cnt++;
               if (m_cnt == ID) begin
                  for (int o = 0; o < OD; o++) begin
                     for (int d = 0; d < ID; d++) begin
                        b.data = vec[d];
                        b.wa   = o * ID + d;
                        b.ba   = o;
                        b.tl   = (d == ID - 1);
                        b.vl   = (d == ID - 1) && (o == OD - 1);
                        exp_q.push_back(b);
                     end
                  end
                  m_fill = 1'b0;
                  m_cnt  = 0;
               end
            end
         end else begin
            e = exp_q[0];
            check("data_out", 128'(data_out), e.data);
            check("weight_addr", 128'(weight_addr), 128'(e.wa));
            check("bias_addr", 128'(bias_addr), 128'(e.ba));
            check("tile_last", 128'(tile_last), 128'(e.tl));
            check("vector_last", 128'(vector_last), 128'(e.vl));
            if (data_out_ready) begin
               void'(exp_q.pop_front());
               out_hs_cnt++;
               if (exp_q.size() == 0) begin
                  m_fill = 1'b1;
                  vec_done++;
               end
            end
         end
      end
   end

   task automatic run_vectors(input int k, input int pv, input int pr);
      int target;
      int n;
      target = vec_done + k;
      n = 0;
      while (vec_done < target && n < 3000) begin
         data_in_valid  = ($urandom_range(99) < pv);
         data_in        = {$urandom, $urandom, $urandom, $urandom};
         data_out_ready = ($urandom_range(99) < pr);
         step();
         n++;
      end
      data_in_valid  = 1'b0;
      data_out_ready = 1'b1;
      check("vec_count", 128'(vec_done), 128'(target));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [127:0] x [3];
      int target;
      int n;

      rst            = 1'b1;
      data_in        = '0;
      data_in_valid  = 1'b0;
      data_out_ready = 1'b1;
      d1_in          = '0;
      d1_in_valid    = 1'b0;
      d1_out_ready   = 1'b1;
      step();
      step();
      check("rst_out_valid", 128'(data_out_valid), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_tile_last", 128'(tile_last), 128'(0));
      check("rst_vector_last", 128'(vector_last), 128'(0));
      check("rst_weight_addr", 128'(weight_addr), 128'(0));
      check("rst_bias_addr", 128'(bias_addr), 128'(0));
      check("rst_d1_valid", 128'(d1_out_valid), 128'(0));
      rst = 1'b0;
      #1;
      check("post_rst_ready", 128'(data_in_ready), 128'(1));
      check("post_rst_d1_ready", 128'(d1_in_ready), 128'(1));
      mon_en = 1'b1;

      // One vector, no back-pressure.
      run_vectors(1, 100, 100);
      // Random back-pressure and upstream gaps.
      run_vectors(20, 70, 50);
      // Upstream valid held high through replay.
      run_vectors(3, 100, 100);
      run_vectors(3, 100, 50);

      // Reset in the middle of replay, after the 4th output beat.
      data_in_valid  = 1'b1;
      data_out_ready = 1'b1;
      target = out_hs_cnt + ID + 1;
      n = 0;
      while (out_hs_cnt < target && n < 100) begin
         data_in = {$urandom, $urandom, $urandom, $urandom};
         step();
         n++;
      end
      check("pre_rst_beats", 128'(out_hs_cnt), 128'(target));
      data_in_valid = 1'b0;
      #1 rst = 1'b1;
      #1;
      check("midrst_out_valid", 128'(data_out_valid), 128'(0));
      check("midrst_busy", 128'(busy), 128'(0));
      check("midrst_weight_addr", 128'(weight_addr), 128'(0));
      check("midrst_vector_last", 128'(vector_last), 128'(0));
      step();
      rst = 1'b0;
      #1;
      check("midrst_ready", 128'(data_in_ready), 128'(1));
      run_vectors(1, 100, 100);

      // Degenerate 1x1 build: one beat in, one beat out.
      for (int k = 0; k < 3; k++) x[k] = {$urandom, $urandom, $urandom, $urandom};
      d1_out_ready = 1'b1;
      d1_in_valid  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         d1_in = x[k];
         @(negedge clk);
         check("d1_ready_fill", 128'(d1_in_ready), 128'(1));
         check("d1_valid_fill", 128'(d1_out_valid), 128'(0));
         step();
         @(negedge clk);
         check("d1_ready_replay", 128'(d1_in_ready), 128'(0));
         check("d1_valid_replay", 128'(d1_out_valid), 128'(1));
         check("d1_data", 128'(d1_out), x[k]);
         check("d1_weight_addr", 128'(d1_wa), 128'(0));
         check("d1_tile_last", 128'(d1_tl), 128'(1));
         check("d1_vector_last", 128'(d1_vl), 128'(1));
         step();
      end
      d1_in_valid = 1'b0;

      step();
      check("end_idle", 128'(busy), 128'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
